ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
Carries decoded control and register-address fields from the decode stage through the E, M and W pipeline registers of the 5-stage RISC-V core. Consumes the control decoder's D-stage outputs and ALU Zero in E. Produces PCSrcE, per-stage controls for datapath muxes and the hazard unit, and a retired-instruction counter. Inserts bubbles on flush and stall.

Parameters:
REG_AW, 5, register-address width (rs1/rs2/rd)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
ValidD  in  1  D stage holds a real instruction
RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoder controls
ResultSrcD  in  2  result mux select (00 ALU, 01 mem, 10 PC+4)
ALUControlD  in  3  ALU operation
Rs1D, Rs2D, RdD  in  REG_AW each  register addresses
FlushE  in  1  squash instruction entering E (from hazard unit)
StallE  in  1  hold E register contents
ZeroE  in  1  ALU zero flag for instruction in E
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each
ResultSrcE  out  2
ALUControlE  out  3
Rs1E, Rs2E, RdE  out  REG_AW each
PCSrcE  out  1  take branch/jump target
RegWriteM, MemWriteM  out  1 each
ResultSrcM  out  2
RdM  out  REG_AW
RegWriteW  out  1
ResultSrcW  out  2
RdW  out  REG_AW
ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
InstRet  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, immediate): every output register 0, including Valid*, all controls, addresses, InstRet. PCSrcE therefore 0.
- Latency: one cycle per stage; a D-stage instruction appears at E next edge, M two edges, W three edges.
- E register update each edge, priority: FlushE > StallE > load.
  - FlushE=1: E becomes bubble: ValidE, RegWriteE, MemWriteE, JumpE, BranchE = 0; ResultSrcE, ALUControlE, ALUSrcE, Rs1E, Rs2E, RdE = 0.
  - StallE=1 (no flush): E holds all fields.
  - else: E loads D fields; ValidD=0 loads as bubble (same as flush values).
- M register: when StallE=1 and FlushE=0, M loads a bubble (all 0); otherwise loads E fields (RegWrite, MemWrite, ResultSrc, Rd, Valid).
- W register: always loads M fields (RegWrite, ResultSrc, Rd, Valid).
- Bubbles never write: RegWrite*/MemWrite* are 0 whenever the matching Valid* is 0.
- PCSrcE combinational: (BranchE & ZeroE) | JumpE. Forced 0 when ValidE=0.
- InstRet: increments by 1 on each edge where ValidW=1; wraps modulo 2^CNT_W from all-ones to 0, no flag.
- Simultaneous FlushE and StallE: flush wins; M still receives the bubble.
- Reset asserted mid-operation clears all stages in the same cycle; first instruction after deassert needs three edges to reach W.
- No combinational path from D inputs to any output except through registers; PCSrcE depends only on E registers and ZeroE.

Decomposition:
- Shared core package: ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4), ALUControl encodings, REG_AW default, and a bubble constant per stage control bundle.
- One sub-module, pipe_stage_reg: parameterised-width register with async reset, enable and clear (clear over enable). Instantiated for E, M and W. The InstRet counter and PCSrcE logic stay in the top module.

Test Plan:
- Reset: drive random inputs with reset=1 -> all outputs 0, InstRet=0. Release reset, issue one add (RegWriteD=1, RdD=5) -> RdW=5, RegWriteW=1 after 3 edges, and InstRet=1 on the 4th edge.
- Branch: BranchD=1 into E with ZeroE=1 -> PCSrcE=1. ZeroE=0 -> PCSrcE=0. JumpD=1 -> PCSrcE=1 regardless of ZeroE.
- Flush: FlushE=1 on the edge a sw (MemWriteD=1) would enter E -> MemWriteE=0, ValidE=0, and MemWriteM=0 the next cycle. InstRet does not count it.
- Stall: lw in E, assert StallE for 1 cycle -> E fields unchanged, M holds bubble (RegWriteM=0, ValidM=0). After release, lw reaches W one cycle late.
- Flush+stall same cycle -> E and M both bubbles.
- Counter wrap: CNT_W=4, retire 17 valid instructions back-to-back -> InstRet=1.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the E/M/W control pipeline: result-mux and ALU
// encodings, default register-address width, and the per-stage control
// bundles together with their bubble (all-zero, non-writing) values.
package ctrl_pipe_pkg;

  localparam int REG_AW_DEF = 5;

  // Result mux select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } e_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } m_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
  } w_ctrl_t;

  // A bubble carries no instruction and never writes anything.
  localparam e_ctrl_t E_BUBBLE = '0;
  localparam m_ctrl_t M_BUBBLE = '0;
  localparam w_ctrl_t W_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register with async reset, enable and synchronous clear.
// Clear has priority over enable so a squash always beats a hold.
// One cycle latency; holds its contents while enable is low.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Stage register: reset, then clear (bubble), then load when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control/register fields through E, M, W; derives PCSrcE.
// One cycle per stage (D->E 1 edge, ->M 2, ->W 3); InstRet counts W retires.
// StallE holds E and injects a bubble into M; FlushE squashes E and wins.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              FlushE,
  input  logic              StallE,
  input  logic              ZeroE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              PCSrcE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic              ValidE,
  output logic              ValidM,
  output logic              ValidW,
  output logic [CNT_W-1:0]  InstRet
);

  localparam int EW = $bits(e_ctrl_t) + 3 * REG_AW;
  localparam int MW = $bits(m_ctrl_t) + REG_AW;
  localparam int WW = $bits(w_ctrl_t) + REG_AW;

  e_ctrl_t           e_ctrl_d, e_ctrl_q;
  m_ctrl_t           m_ctrl_d, m_ctrl_q;
  w_ctrl_t           w_ctrl_d, w_ctrl_q;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [EW-1:0]     e_d, e_q;
  logic [MW-1:0]     m_d, m_q;
  logic [WW-1:0]     w_d, w_q;

  // An invalid D slot enters E as a full bubble, addresses included, so the
  // hazard unit never sees stale register numbers from a dead slot.
  assign e_ctrl_d = ValidD ? '{valid:       1'b1,
                               reg_write:   RegWriteD,
                               mem_write:   MemWriteD,
                               jump:        JumpD,
                               branch:      BranchD,
                               alu_src:     ALUSrcD,
                               result_src:  ResultSrcD,
                               alu_control: ALUControlD}
                           : E_BUBBLE;
  assign rs1_d = ValidD ? Rs1D : '0;
  assign rs2_d = ValidD ? Rs2D : '0;
  assign rd_d  = ValidD ? RdD  : '0;
  assign e_d   = {e_ctrl_d, rs1_d, rs2_d, rd_d};

  // Flush clears E even when a stall is requested at the same time.
  pipe_stage_reg #(.W(EW)) u_e_reg (
    .clk (clk),
    .rst (reset),
    .en  (~StallE),
    .clr (FlushE),
    .d   (e_d),
    .q   (e_q)
  );

  assign {e_ctrl_q, Rs1E, Rs2E, RdE} = e_q;
  assign ValidE      = e_ctrl_q.valid;
  assign RegWriteE   = e_ctrl_q.reg_write;
  assign MemWriteE   = e_ctrl_q.mem_write;
  assign JumpE       = e_ctrl_q.jump;
  assign BranchE     = e_ctrl_q.branch;
  assign ALUSrcE     = e_ctrl_q.alu_src;
  assign ResultSrcE  = e_ctrl_q.result_src;
  assign ALUControlE = e_ctrl_q.alu_control;

  // Redirect only for a live instruction in E.
  assign PCSrcE = e_ctrl_q.valid & ((e_ctrl_q.branch & ZeroE) | e_ctrl_q.jump);

  assign m_ctrl_d = '{valid:      e_ctrl_q.valid,
                      reg_write:  e_ctrl_q.reg_write,
                      mem_write:  e_ctrl_q.mem_write,
                      result_src: e_ctrl_q.result_src};
  assign m_d = {m_ctrl_d, RdE};

  // While E holds (stall, with or without flush) the instruction in E must
  // not also advance into M, so M takes a bubble instead.
  pipe_stage_reg #(.W(MW)) u_m_reg (
    .clk (clk),
    .rst (reset),
    .en  (1'b1),
    .clr (StallE),
    .d   (m_d),
    .q   (m_q)
  );

  assign {m_ctrl_q, RdM} = m_q;
  assign ValidM     = m_ctrl_q.valid;
  assign RegWriteM  = m_ctrl_q.reg_write;
  assign MemWriteM  = m_ctrl_q.mem_write;
  assign ResultSrcM = m_ctrl_q.result_src;

  assign w_ctrl_d = '{valid:      m_ctrl_q.valid,
                      reg_write:  m_ctrl_q.reg_write,
                      result_src: m_ctrl_q.result_src};
  assign w_d = {w_ctrl_d, RdM};

  pipe_stage_reg #(.W(WW)) u_w_reg (
    .clk (clk),
    .rst (reset),
    .en  (1'b1),
    .clr (1'b0),
    .d   (w_d),
    .q   (w_q)
  );

  assign {w_ctrl_q, RdW} = w_q;
  assign ValidW     = w_ctrl_q.valid;
  assign RegWriteW  = w_ctrl_q.reg_write;
  assign ResultSrcW = w_ctrl_q.result_src;

  // Count each instruction as it leaves W; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       InstRet <= '0;
    else if (ValidW) InstRet <= InstRet + CNT_W'(1);
  end

endmodule
